// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: instruction-memory handshake, redirect/halt controls and decode-side output.
// FETCH_QUEUE_PERF_EN adds the two performance counter outputs.
interface fetch_queue_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;
`ifdef FETCH_QUEUE_PERF_EN
   logic [31:0] perf_flush_cnt;
   logic [31:0] perf_empty_cycles;
`endif

   modport master (
      output imem_req, imem_addr, inst_valid, inst, inst_pc,
`ifdef FETCH_QUEUE_PERF_EN
      output perf_flush_cnt, perf_empty_cycles,
`endif
      input  imem_ack, imem_rdata, redirect_valid, redirect_pc, halt, inst_ready
   );

   modport slave (
      input  imem_req, imem_addr, inst_valid, inst, inst_pc,
`ifdef FETCH_QUEUE_PERF_EN
      input  perf_flush_cnt, perf_empty_cycles,
`endif
      output imem_ack, imem_rdata, redirect_valid, redirect_pc, halt, inst_ready
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front-end: one outstanding imem request, FIFO of {inst, pc} toward decode.
// Optional perf counters via FETCH_QUEUE_PERF_EN.
module fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic         clk,
   input logic         reset,
   fetch_queue_if.master bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {StIdle, StReq, StDrain} state_e;

   state_e         r_state;
   logic           r_req;
   logic [31:0]    r_addr;
   logic [31:0]    r_fetch_pc;
   logic [AW:0]    r_count;
   logic [AW-1:0]  r_rd_ptr;
   logic [AW-1:0]  r_wr_ptr;
   logic [31:0]    r_inst_mem [DEPTH];
   logic [31:0]    r_pc_mem   [DEPTH];

   logic           w_inst_valid;
   logic           w_ack;
   logic           w_push;
   logic           w_pop;
   logic [AW:0]    w_count_after;
   logic           w_room;
   logic [31:0]    w_next_addr;
   logic [31:0]    w_target;

   assign w_inst_valid  = (r_count != '0);
   assign w_ack         = r_req && bus.imem_ack;
   // Data acked while draining belongs to the pre-redirect path and is dropped.
   assign w_push        = w_ack && (r_state == StReq);
   assign w_pop         = w_inst_valid && bus.inst_ready;
   assign w_count_after = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
   assign w_room        = (w_count_after < FULL_CNT);
   assign w_next_addr   = r_addr + 32'd4;
   assign w_target      = bus.redirect_pc & ~32'h3;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= StIdle;
         r_req      <= 1'b0;
         r_addr     <= RESET_PC;
         r_fetch_pc <= RESET_PC;
         r_count    <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_inst_mem[i] <= '0;
            r_pc_mem[i]   <= '0;
         end
      end else if (bus.redirect_valid) begin
         r_count    <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_fetch_pc <= w_target;
         if (r_state == StIdle || w_ack) begin
            r_state <= bus.halt ? StIdle : StReq;
            r_req   <= !bus.halt;
            if (!bus.halt) begin
               r_addr <= w_target;
            end
         end else begin
            // Request still in flight: keep it stable until the memory acks.
            r_state <= StDrain;
         end
      end else begin
         if (w_push) begin
            r_inst_mem[r_wr_ptr] <= bus.imem_rdata;
            r_pc_mem[r_wr_ptr]   <= r_addr;
            r_wr_ptr             <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_count <= w_count_after;
         case (r_state)
            StIdle: begin
               if (r_count < FULL_CNT && !bus.halt) begin
                  r_state <= StReq;
                  r_req   <= 1'b1;
                  r_addr  <= r_fetch_pc;
               end
            end
            StReq: begin
               if (w_ack) begin
                  r_fetch_pc <= w_next_addr;
                  if (w_room && !bus.halt) begin
                     r_addr <= w_next_addr;
                  end else begin
                     r_state <= StIdle;
                     r_req   <= 1'b0;
                  end
               end
            end
            StDrain: begin
               if (w_ack) begin
                  if (!bus.halt) begin
                     r_state <= StReq;
                     r_addr  <= r_fetch_pc;
                  end else begin
                     r_state <= StIdle;
                     r_req   <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= StIdle;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.imem_req   = r_req;
   assign bus.imem_addr  = r_addr;
   assign bus.inst_valid = w_inst_valid;
   assign bus.inst       = r_inst_mem[r_rd_ptr];
   assign bus.inst_pc    = r_pc_mem[r_rd_ptr];

`ifdef FETCH_QUEUE_PERF_EN
   logic [31:0] r_perf_flush;
   logic [31:0] r_perf_empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_perf_flush <= '0;
         r_perf_empty <= '0;
      end else begin
         if (bus.redirect_valid && r_perf_flush != 32'hFFFF_FFFF) begin
            r_perf_flush <= r_perf_flush + 32'd1;
         end
         if (!w_inst_valid && bus.inst_ready && r_perf_empty != 32'hFFFF_FFFF) begin
            r_perf_empty <= r_perf_empty + 32'd1;
         end
      end
   end

   assign bus.perf_flush_cnt    = r_perf_flush;
   assign bus.perf_empty_cycles = r_perf_empty;
`else
   // Counters absent in this build.
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a cycle table for start-up and RESET_PC wrap,
// plus hand-written sequences for backpressure, redirects and halt.
module tb_fetch_queue;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_fail;
   int   lat;
   int   wait_cnt;
   bit   nop_mode;
   logic [31:0] ack_q [$];
   logic [31:0] pop_q [$];

   fetch_queue_if bus ();
   fetch_queue_if bus2 ();

   fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: ack on the lat-th cycle of a request; data is ~addr or a NOP.
   assign bus.imem_ack   = bus.imem_req && (wait_cnt == lat - 1);
   assign bus.imem_rdata = nop_mode ? 32'h0000_0013 : ~bus.imem_addr;

   always @(posedge clk) begin
      if (reset || !bus.imem_req || bus.imem_ack) wait_cnt <= 0;
      else wait_cnt <= wait_cnt + 1;
   end

   assign bus2.imem_ack       = bus2.imem_req;
   assign bus2.imem_rdata     = bus2.imem_addr;
   assign bus2.redirect_valid = 1'b0;
   assign bus2.redirect_pc    = 32'h0;
   assign bus2.halt           = 1'b0;
   assign bus2.inst_ready     = 1'b1;

   always @(posedge clk) begin
      if (!reset && bus.imem_req && bus.imem_ack) ack_q.push_back(bus.imem_addr);
      if (!reset && bus.inst_valid && bus.inst_ready && !bus.redirect_valid)
         pop_q.push_back(bus.inst_pc);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset(input int l, input bit nop, input logic rdy);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      lat = l;
      nop_mode = nop;
      bus.inst_ready = rdy;
      bus.redirect_valid = 1'b0;
      bus.halt = 1'b0;
      reset = 1'b0;
   endtask

   // Poll negedges until the DUT requests address a (optionally only before its ack).
   task automatic wait_req(input logic [31:0] a, input bit before_ack, output bit found);
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk);
         if (bus.imem_req && bus.imem_addr == a && (!before_ack || !bus.imem_ack)) found = 1'b1;
      end
   endtask

   function automatic logic [31:0] q_at(input logic [31:0] q [$], input int idx);
      if (idx < q.size()) return q[idx];
      return 32'hDEAD_BEEF;
   endfunction

   typedef struct {
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] addr2;
   } vec_t;

   vec_t vecs [4];

   initial begin
      bit found;
      int base_a;
      int base_p;
      int cnt8;
      n_cmp = 0;
      n_fail = 0;
      vecs[0] = '{1'b1, 32'h0, 1'b0, 32'h0, 32'h0,          32'hFFFF_FFF8};
      vecs[1] = '{1'b1, 32'h4, 1'b1, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
      vecs[2] = '{1'b1, 32'h8, 1'b1, 32'h4, 32'hFFFF_FFFB, 32'h0000_0000};
      vecs[3] = '{1'b1, 32'hC, 1'b1, 32'h8, 32'hFFFF_FFF7, 32'h0000_0004};

      reset = 1'b1;
      lat = 1;
      nop_mode = 1'b0;
      bus.inst_ready = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.halt = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);

      // Reset state
      chk("rst_req", {31'h0, bus.imem_req}, 32'h0);
      chk("rst_addr", bus.imem_addr, 32'h0);
      chk("rst_valid", {31'h0, bus.inst_valid}, 32'h0);
      chk("rst_inst", bus.inst, 32'h0);
      chk("rst_pc", bus.inst_pc, 32'h0);
      chk("rst_addr_wrap", bus2.imem_addr, 32'hFFFF_FFF8);
      chk("rst_req_wrap", {31'h0, bus2.imem_req}, 32'h0);
      reset = 1'b0;

      // Start-up streaming with a 0-wait memory, both DUTs in lockstep
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("v%0d_req", k), {31'h0, bus.imem_req}, {31'h0, vecs[k].req});
         chk($sformatf("v%0d_addr", k), bus.imem_addr, vecs[k].addr);
         chk($sformatf("v%0d_valid", k), {31'h0, bus.inst_valid}, {31'h0, vecs[k].valid});
         chk($sformatf("v%0d_pc", k), bus.inst_pc, vecs[k].pc);
         chk($sformatf("v%0d_inst", k), bus.inst, vecs[k].inst);
         chk($sformatf("v%0d_addr_wrap", k), bus2.imem_addr, vecs[k].addr2);
      end

      // Backpressure: FIFO fills with DEPTH entries, then fetching stops
      do_reset(1, 1'b1, 1'b0);
      base_a = ack_q.size();
      repeat (10) @(negedge clk);
      chk("full_acks", ack_q.size() - base_a, 32'd4);
      chk("full_req", {31'h0, bus.imem_req}, 32'h0);
      chk("full_valid", {31'h0, bus.inst_valid}, 32'h1);
      chk("full_pc", bus.inst_pc, 32'h0);
      chk("full_inst", bus.inst, 32'h0000_0013);
      base_p = pop_q.size();
      bus.inst_ready = 1'b1;
      repeat (6) @(negedge clk);
      for (int i = 0; i < 4; i++) chk($sformatf("drain_pc%0d", i), q_at(pop_q, base_p + i), 32'(4 * i));
      chk("resume_addr", q_at(ack_q, base_a + 4), 32'h10);

      // Redirect while a 3-cycle request is outstanding
      do_reset(3, 1'b0, 1'b1);
      wait_req(32'h8, 1'b1, found);
      chk("t3_found", {31'h0, found}, 32'h1);
      @(negedge clk);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h103;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      base_p = pop_q.size();
      chk("drain_req", {31'h0, bus.imem_req}, 32'h1);
      chk("drain_addr", bus.imem_addr, 32'h8);
      chk("drain_valid", {31'h0, bus.inst_valid}, 32'h0);
      @(negedge clk);
      chk("redir_req", {31'h0, bus.imem_req}, 32'h1);
      chk("redir_addr", bus.imem_addr, 32'h100);
      repeat (8) @(negedge clk);
      chk("redir_first_pc", q_at(pop_q, base_p), 32'h100);
      cnt8 = 0;
      for (int i = base_p; i < pop_q.size(); i++) if (pop_q[i] == 32'h8) cnt8++;
      chk("drain_dropped", cnt8, 32'h0);

      // Redirect coinciding with ack and pop
      do_reset(1, 1'b0, 1'b1);
      wait_req(32'h8, 1'b0, found);
      chk("t4_found", {31'h0, found}, 32'h1);
      base_p = pop_q.size();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h40;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      chk("ack_redir_valid", {31'h0, bus.inst_valid}, 32'h0);
      chk("ack_redir_addr", bus.imem_addr, 32'h40);
      chk("ack_redir_req", {31'h0, bus.imem_req}, 32'h1);
      repeat (4) @(negedge clk);
      chk("ack_redir_pc0", q_at(pop_q, base_p), 32'h40);
      chk("ack_redir_pc1", q_at(pop_q, base_p + 1), 32'h44);

      // Halt with a 2-cycle request pending
      do_reset(2, 1'b0, 1'b1);
      wait_req(32'h20, 1'b1, found);
      chk("t5_found", {31'h0, found}, 32'h1);
      base_a = ack_q.size();
      bus.halt = 1'b1;
      @(negedge clk);
      bus.inst_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("halt_valid%0d", i), {31'h0, bus.inst_valid}, 32'h1);
         chk($sformatf("halt_pc%0d", i), bus.inst_pc, 32'h20);
         chk($sformatf("halt_req%0d", i), {31'h0, bus.imem_req}, 32'h0);
      end
      chk("halt_acks", ack_q.size() - base_a, 32'd1);
      chk("halt_ack_addr", q_at(ack_q, base_a), 32'h20);
      bus.inst_ready = 1'b1;
      @(negedge clk);
      chk("halt_popped", {31'h0, bus.inst_valid}, 32'h0);
      chk("halt_noreq", {31'h0, bus.imem_req}, 32'h0);
      bus.halt = 1'b0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
